// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types for the data-memory port arbiter: FSM states, grant owner
// and the fixed access size used for debug/loader traffic.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE         = 2'd0,
      CORE_RD_WAIT = 2'd1,
      DBG_RD_WAIT  = 2'd2
   } arb_state_e;

   typedef enum logic {
      GNT_CORE = 1'b0,
      GNT_DBG  = 1'b1
   } gnt_e;

   // Debug/loader accesses are always full words.
   localparam logic [2:0] DBG_FUNCT3 = 3'b010;

endpackage

// File: rtl/dmem_port_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; holds when neither inc nor clr.
// Used to count consecutive denied debug cycles.
module sat_counter #(
   parameter int  MAX   = 8,
   localparam int CNT_W = $clog2(MAX + 1)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] cnt
);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != CNT_W'(MAX))) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the MEM stage and a debug/loader
// master: fixed core priority with a starvation limit for the debug side.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// IDLE         | port free; grants issued here (writes finish in this cycle)
// CORE_RD_WAIT | core read issued last cycle; return mem_rdata to core
// DBG_RD_WAIT  | dbg read issued last cycle; return mem_rdata to dbg
module dmem_port_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W     = 9,
   parameter int DATA_W     = 32,
   parameter int STARVE_LIM = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              core_req_rd,
   input  logic              core_req_wr,
   input  logic [ADDR_W-1:0] core_addr,
   input  logic [DATA_W-1:0] core_wdata,
   input  logic [2:0]        core_funct3,
   output logic              core_stall,
   output logic              core_rvalid,
   output logic [DATA_W-1:0] core_rdata,
   input  logic              dbg_req_valid,
   input  logic              dbg_req_we,
   input  logic [ADDR_W-1:0] dbg_addr,
   input  logic [DATA_W-1:0] dbg_wdata,
   output logic              dbg_ready,
   output logic              dbg_rvalid,
   output logic [DATA_W-1:0] dbg_rdata,
   output logic              mem_rd,
   output logic              mem_wr,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   output logic [2:0]        mem_funct3,
   input  logic [DATA_W-1:0] mem_rdata
);

   localparam int CNT_W = $clog2(STARVE_LIM + 1);

   arb_state_e        state_q, state_d;
   gnt_e              gnt_sel;
   logic              gnt_valid;
   logic              gnt_is_wr;
   logic              core_req;
   logic              core_done;
   logic              starve_full;
   logic              starve_inc;
   logic              starve_clr;
   logic [CNT_W-1:0]  starve_cnt;
   logic [DATA_W-1:0] core_rdata_q;
   logic [DATA_W-1:0] dbg_rdata_q;

   assign core_req    = core_req_rd | core_req_wr;
   assign starve_full = (starve_cnt == CNT_W'(STARVE_LIM));

   // Grant decision; only IDLE can grant, and nothing is granted during reset.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_sel   = GNT_CORE;
      if ((state_q == IDLE) && !reset) begin
         if (dbg_req_valid && (!core_req || starve_full)) begin
            gnt_valid = 1'b1;
            gnt_sel   = GNT_DBG;
         end else if (core_req) begin
            gnt_valid = 1'b1;
         end
      end
   end

   // A simultaneous core read+write is treated as a write.
   assign gnt_is_wr = (gnt_sel == GNT_DBG) ? dbg_req_we : core_req_wr;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (gnt_valid && !gnt_is_wr) begin
               state_d = (gnt_sel == GNT_DBG) ? DBG_RD_WAIT : CORE_RD_WAIT;
            end
         end
         CORE_RD_WAIT: state_d = IDLE;
         DBG_RD_WAIT:  state_d = IDLE;
         default:      state_d = IDLE;
      endcase
   end

   always_comb begin
      mem_rd      = 1'b0;
      mem_wr      = 1'b0;
      mem_addr    = '0;
      mem_wdata   = '0;
      mem_funct3  = '0;
      dbg_ready   = 1'b0;
      core_rvalid = (state_q == CORE_RD_WAIT) && !reset;
      dbg_rvalid  = (state_q == DBG_RD_WAIT) && !reset;
      if (gnt_valid) begin
         mem_wr = gnt_is_wr;
         mem_rd = !gnt_is_wr;
         if (gnt_sel == GNT_DBG) begin
            mem_addr   = dbg_addr;
            mem_wdata  = dbg_wdata;
            mem_funct3 = DBG_FUNCT3;
            dbg_ready  = 1'b1;
         end else begin
            mem_addr   = core_addr;
            mem_wdata  = core_wdata;
            mem_funct3 = core_funct3;
         end
      end
   end

   assign core_done  = (gnt_valid && (gnt_sel == GNT_CORE) && core_req_wr) || core_rvalid;
   assign core_stall = core_req && !core_done && !reset;

   // Read data is presented live on the return cycle and held afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         core_rdata_q <= '0;
         dbg_rdata_q  <= '0;
      end else begin
         if (core_rvalid) core_rdata_q <= mem_rdata;
         if (dbg_rvalid)  dbg_rdata_q  <= mem_rdata;
      end
   end

   assign core_rdata = reset ? '0 : (core_rvalid ? mem_rdata : core_rdata_q);
   assign dbg_rdata  = reset ? '0 : (dbg_rvalid  ? mem_rdata : dbg_rdata_q);

   // Starvation count only moves in IDLE; it is frozen across read-wait cycles.
   assign starve_inc = (state_q == IDLE) && dbg_req_valid && !dbg_ready;
   assign starve_clr = (state_q == IDLE) && (dbg_ready || !dbg_req_valid);

   sat_counter #(.MAX(STARVE_LIM)) u_starve_cnt (
      .clk   (clk),
      .reset (reset),
      .inc   (starve_inc),
      .clr   (starve_clr),
      .cnt   (starve_cnt)
   );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a small word memory behind the port.
module tb_dmem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        core_req_rd, core_req_wr;
   logic [8:0]  core_addr;
   logic [31:0] core_wdata;
   logic [2:0]  core_funct3;
   logic        core_stall, core_rvalid;
   logic [31:0] core_rdata;
   logic        dbg_req_valid, dbg_req_we;
   logic [8:0]  dbg_addr;
   logic [31:0] dbg_wdata;
   logic        dbg_ready, dbg_rvalid;
   logic [31:0] dbg_rdata;
   logic        mem_rd, mem_wr;
   logic [8:0]  mem_addr;
   logic [31:0] mem_wdata;
   logic [2:0]  mem_funct3;
   logic [31:0] mem_rdata = 32'h0;
   logic [31:0] mem [0:127];

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   dmem_port_arbiter #(.ADDR_W(9), .DATA_W(32), .STARVE_LIM(8)) dut (
      .clk           (clk),
      .reset         (reset),
      .core_req_rd   (core_req_rd),
      .core_req_wr   (core_req_wr),
      .core_addr     (core_addr),
      .core_wdata    (core_wdata),
      .core_funct3   (core_funct3),
      .core_stall    (core_stall),
      .core_rvalid   (core_rvalid),
      .core_rdata    (core_rdata),
      .dbg_req_valid (dbg_req_valid),
      .dbg_req_we    (dbg_req_we),
      .dbg_addr      (dbg_addr),
      .dbg_wdata     (dbg_wdata),
      .dbg_ready     (dbg_ready),
      .dbg_rvalid    (dbg_rvalid),
      .dbg_rdata     (dbg_rdata),
      .mem_rd        (mem_rd),
      .mem_wr        (mem_wr),
      .mem_addr      (mem_addr),
      .mem_wdata     (mem_wdata),
      .mem_funct3    (mem_funct3),
      .mem_rdata     (mem_rdata)
   );

   // Word-addressed data memory with 1-cycle read latency.
   always @(posedge clk) begin
      if (mem_wr) mem[mem_addr[8:2]] <= mem_wdata;
      if (mem_rd) mem_rdata <= mem[mem_addr[8:2]];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic quiet();
      core_req_rd   = 1'b0;
      core_req_wr   = 1'b0;
      core_addr     = '0;
      core_wdata    = '0;
      core_funct3   = '0;
      dbg_req_valid = 1'b0;
      dbg_req_we    = 1'b0;
      dbg_addr      = '0;
      dbg_wdata     = '0;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic all_zero(input string tag);
      chk({tag, ".mem_rd"},      32'(mem_rd),      32'h0);
      chk({tag, ".mem_wr"},      32'(mem_wr),      32'h0);
      chk({tag, ".mem_addr"},    32'(mem_addr),    32'h0);
      chk({tag, ".core_stall"},  32'(core_stall),  32'h0);
      chk({tag, ".core_rvalid"}, 32'(core_rvalid), 32'h0);
      chk({tag, ".core_rdata"},  core_rdata,       32'h0);
      chk({tag, ".dbg_ready"},   32'(dbg_ready),   32'h0);
      chk({tag, ".dbg_rvalid"},  32'(dbg_rvalid),  32'h0);
   endtask

   initial begin
      quiet();
      reset = 1'b1;
      next_cycle();
      @(negedge clk);
      all_zero("rst");
      next_cycle();
      reset = 1'b0;
      @(negedge clk);
      all_zero("post_rst");
      chk("post_rst.state", 32'(dut.state_q), 32'd0);
      chk("post_rst.starve", 32'(dut.starve_cnt), 32'd0);

      // 1: core store
      core_req_wr = 1'b1; core_addr = 9'h010; core_wdata = 32'hDEADBEEF; core_funct3 = 3'b010;
      @(negedge clk);
      chk("t1.mem_wr",    32'(mem_wr),     32'h1);
      chk("t1.mem_rd",    32'(mem_rd),     32'h0);
      chk("t1.mem_addr",  32'(mem_addr),   32'h010);
      chk("t1.mem_wdata", mem_wdata,       32'hDEADBEEF);
      chk("t1.funct3",    32'(mem_funct3), 32'h2);
      chk("t1.stall",     32'(core_stall), 32'h0);
      next_cycle();

      // 2: core load of the same word
      core_req_wr = 1'b0; core_req_rd = 1'b1; core_wdata = 32'h0;
      @(negedge clk);
      chk("t2.c0.mem_rd", 32'(mem_rd),      32'h1);
      chk("t2.c0.stall",  32'(core_stall),  32'h1);
      chk("t2.c0.rvalid", 32'(core_rvalid), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("t2.c1.rvalid", 32'(core_rvalid), 32'h1);
      chk("t2.c1.rdata",  core_rdata,       32'hDEADBEEF);
      chk("t2.c1.stall",  32'(core_stall),  32'h0);
      chk("t2.c1.mem_rd", 32'(mem_rd),      32'h0);
      next_cycle();
      quiet();
      @(negedge clk);
      chk("t2.c2.state",  32'(dut.state_q), 32'd0);
      chk("t2.c2.rvalid", 32'(core_rvalid), 32'h0);
      chk("t2.c2.hold",   core_rdata,       32'hDEADBEEF);

      // 3: core store collides with dbg write
      core_req_wr = 1'b1; core_addr = 9'h030; core_wdata = 32'hAAAA5555; core_funct3 = 3'b010;
      dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_addr = 9'h020; dbg_wdata = 32'h12345678;
      @(negedge clk);
      chk("t3.c0.addr",  32'(mem_addr),  32'h030);
      chk("t3.c0.ready", 32'(dbg_ready), 32'h0);
      next_cycle();
      core_req_wr = 1'b0; core_addr = '0; core_wdata = '0; core_funct3 = '0;
      @(negedge clk);
      chk("t3.c1.ready",  32'(dbg_ready),  32'h1);
      chk("t3.c1.mem_wr", 32'(mem_wr),     32'h1);
      chk("t3.c1.addr",   32'(mem_addr),   32'h020);
      chk("t3.c1.wdata",  mem_wdata,       32'h12345678);
      chk("t3.c1.funct3", 32'(mem_funct3), 32'h2);
      next_cycle();
      quiet();

      // 4: continuous core stores starve dbg until the limit
      dbg_req_valid = 1'b1; dbg_req_we = 1'b1; dbg_addr = 9'h060; dbg_wdata = 32'h0BADF00D;
      core_req_wr = 1'b1; core_funct3 = 3'b010;
      for (int i = 0; i < 8; i++) begin
         core_addr  = 9'(9'h100 + 4 * i);
         core_wdata = 32'(i);
         @(negedge clk);
         chk($sformatf("t4.c%0d.ready", i), 32'(dbg_ready), 32'h0);
         chk($sformatf("t4.c%0d.addr", i),  32'(mem_addr),  32'(9'h100 + 4 * i));
         next_cycle();
      end
      core_addr = 9'h120; core_wdata = 32'h8;
      @(negedge clk);
      chk("t4.c8.starve", 32'(dut.starve_cnt), 32'd8);
      chk("t4.c8.ready",  32'(dbg_ready),  32'h1);
      chk("t4.c8.stall",  32'(core_stall), 32'h1);
      chk("t4.c8.addr",   32'(mem_addr),   32'h060);
      next_cycle();
      dbg_req_valid = 1'b0;
      @(negedge clk);
      chk("t4.c9.addr",   32'(mem_addr),   32'h120);
      chk("t4.c9.stall",  32'(core_stall), 32'h0);
      chk("t4.c9.starve", 32'(dut.starve_cnt), 32'd0);
      next_cycle();
      quiet();

      // 5: dbg read of the word written in test 3
      dbg_req_valid = 1'b1; dbg_req_we = 1'b0; dbg_addr = 9'h020;
      @(negedge clk);
      chk("t5.c0.ready",  32'(dbg_ready),  32'h1);
      chk("t5.c0.mem_rd", 32'(mem_rd),     32'h1);
      chk("t5.c0.funct3", 32'(mem_funct3), 32'h2);
      next_cycle();
      quiet();
      @(negedge clk);
      chk("t5.c1.rvalid", 32'(dbg_rvalid),  32'h1);
      chk("t5.c1.rdata",  dbg_rdata,        32'h12345678);
      chk("t5.c1.core_rv", 32'(core_rvalid), 32'h0);
      chk("t5.c1.ready",  32'(dbg_ready),   32'h0);
      next_cycle();

      // 6: reset lands in CORE_RD_WAIT
      core_req_rd = 1'b1; core_addr = 9'h010; core_funct3 = 3'b010;
      @(negedge clk);
      chk("t6.c0.mem_rd", 32'(mem_rd), 32'h1);
      next_cycle();
      reset = 1'b1;
      @(negedge clk);
      chk("t6.c1.rvalid", 32'(core_rvalid), 32'h0);
      next_cycle();
      reset = 1'b0;
      quiet();
      @(negedge clk);
      all_zero("t6.c2");
      chk("t6.c2.state", 32'(dut.state_q), 32'd0);
      next_cycle();
      @(negedge clk);
      chk("t6.c3.rvalid", 32'(core_rvalid), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

   initial begin
      #20000;
      n_err++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule
